ahb_lite_master_if: RTL and testbench

// - Bridges the RISC-V pipeline's simple load/store request port to the AHB-Lite slave side of AHB_APB_UART.
// - Converts one CPU request into one AHB single transfer: address phase, then data phase.
// - Returns read data or an error flag as a one-cycle response pulse.
// - Sits directly upstream of AHB_APB_UART; allows one outstanding transfer (no pipelining of requests).

---
 rtl/ahb_pkg.sv | 35 +++
 rtl/ahb_lane_align.sv | 54 +++++
 rtl/ahb_lite_master_if.sv | 229 ++++++++++++++++++++++
 tb/tb_ahb_lite_master_if.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and constants for the CPU-side bus masters.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_t;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // Master transfer FSM states, also used by the APB-side bridge.
  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_ADDR = 3'b001,
    ST_DATA = 3'b010,
    ST_ERR  = 3'b011,
    ST_RESP = 3'b100
  } master_state_t;

endpackage

// File: rtl/ahb_lane_align.sv
// Byte-lane handling for a 32-bit AHB master: write-data replication,
// read-data extraction and request legality (size / alignment) check.
module ahb_lane_align
  import ahb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        req_size,
  input  logic [1:0]        req_addr_lo,
  input  logic [2:0]        xfer_size,
  input  logic [1:0]        xfer_addr_lo,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] hrdata,
  output logic [DATA_W-1:0] hwdata_rep,
  output logic [DATA_W-1:0] rdata_ext,
  output logic              req_bad
);

  logic [DATA_W-1:0] shifted_s;

  assign shifted_s = hrdata >> {xfer_addr_lo, 3'b000};

  // Flag illegal sizes and addresses not aligned to the access size.
  always_comb begin
    req_bad = 1'b1;
    case (req_size)
      HSIZE_BYTE: req_bad = 1'b0;
      HSIZE_HALF: req_bad = req_addr_lo[0];
      HSIZE_WORD: req_bad = (req_addr_lo != 2'b00);
      default:    req_bad = 1'b1;
    endcase
  end

  // Replicate right-aligned store data onto every byte lane.
  always_comb begin
    hwdata_rep = wdata;
    case (xfer_size)
      HSIZE_BYTE: hwdata_rep = {(DATA_W/8){wdata[7:0]}};
      HSIZE_HALF: hwdata_rep = {(DATA_W/16){wdata[15:0]}};
      default:    hwdata_rep = wdata;
    endcase
  end

  // Pull the addressed lane(s) down to the LSBs and zero-extend.
  always_comb begin
    rdata_ext = shifted_s;
    case (xfer_size)
      HSIZE_BYTE: rdata_ext = {{(DATA_W-8){1'b0}}, shifted_s[7:0]};
      HSIZE_HALF: rdata_ext = {{(DATA_W-16){1'b0}}, shifted_s[15:0]};
      default:    rdata_ext = shifted_s;
    endcase
  end

endmodule

// File: rtl/ahb_lite_master_if.sv
// Converts one CPU load/store request into a single AHB-Lite transfer and
// returns a one-cycle response pulse. One transfer outstanding at a time.
module ahb_lite_master_if
  import ahb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [2:0]        req_size_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_tmo_o,
  output logic              HSEL_o,
  output logic [1:0]        HTRANS_o,
  output logic              HWRITE_o,
  output logic [2:0]        HSIZE_o,
  output logic [2:0]        HBURST_o,
  output logic [ADDR_W-1:0] HADDR_o,
  output logic [DATA_W-1:0] HWDATA_o,
  input  logic              HREADY_i,
  input  logic [1:0]        HRESP_i,
  input  logic [DATA_W-1:0] HRDATA_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  // Abort on the wait cycle that brings the count to TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  master_state_t     state_r,     state_next_s;
  logic [ADDR_W-1:0] addr_r,      addr_next_s;
  logic [2:0]        size_r,      size_next_s;
  logic              write_r,     write_next_s;
  logic [DATA_W-1:0] wdata_r,     wdata_next_s;
  logic [CNT_W-1:0]  cnt_r,       cnt_next_s;
  logic              hsel_r,      hsel_next_s;
  htrans_t           htrans_r,    htrans_next_s;
  logic [DATA_W-1:0] hwdata_r,    hwdata_next_s;
  logic              rsp_valid_r, rsp_valid_next_s;
  logic [DATA_W-1:0] rsp_rdata_r, rsp_rdata_next_s;
  logic              rsp_err_r,   rsp_err_next_s;
  logic              rsp_tmo_r,   rsp_tmo_next_s;

  logic [DATA_W-1:0] hwdata_rep_s;
  logic [DATA_W-1:0] rdata_ext_s;
  logic              req_bad_s;
  logic              hresp_ok_s;
  logic              tmo_hit_s;
  logic [CNT_W-1:0]  cnt_inc_s;

  ahb_lane_align #(
    .DATA_W (DATA_W)
  ) u_lane_align (
    .req_size     (req_size_i),
    .req_addr_lo  (req_addr_i[1:0]),
    .xfer_size    (size_r),
    .xfer_addr_lo (addr_r[1:0]),
    .wdata        (wdata_r),
    .hrdata       (HRDATA_i),
    .hwdata_rep   (hwdata_rep_s),
    .rdata_ext    (rdata_ext_s),
    .req_bad      (req_bad_s)
  );

  assign hresp_ok_s = (HRESP_i == HRESP_OKAY);
  assign cnt_inc_s  = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);
  assign tmo_hit_s  = !HREADY_i && (cnt_r == CNT_LAST);

  assign req_ready_o = (state_r == ST_IDLE);
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_rdata_o = rsp_rdata_r;
  assign rsp_err_o   = rsp_err_r;
  assign rsp_tmo_o   = rsp_tmo_r;
  assign HSEL_o      = hsel_r;
  assign HTRANS_o    = htrans_r;
  assign HWRITE_o    = write_r;
  assign HSIZE_o     = size_r;
  assign HBURST_o    = HBURST_SINGLE;
  assign HADDR_o     = addr_r;
  assign HWDATA_o    = hwdata_r;

  // Next-state and next-output decode; bus and response signals default idle.
  always_comb begin
    state_next_s     = state_r;
    addr_next_s      = addr_r;
    size_next_s      = size_r;
    write_next_s     = write_r;
    wdata_next_s     = wdata_r;
    cnt_next_s       = cnt_r;
    hsel_next_s      = 1'b0;
    htrans_next_s    = HTRANS_IDLE;
    hwdata_next_s    = hwdata_r;
    rsp_valid_next_s = 1'b0;
    rsp_rdata_next_s = {DATA_W{1'b0}};
    rsp_err_next_s   = 1'b0;
    rsp_tmo_next_s   = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (req_valid_i) begin
          addr_next_s  = req_addr_i;
          size_next_s  = req_size_i;
          write_next_s = req_write_i;
          wdata_next_s = req_wdata_i;
          cnt_next_s   = {CNT_W{1'b0}};
          if (req_bad_s) begin
            state_next_s     = ST_RESP;
            rsp_valid_next_s = 1'b1;
            rsp_err_next_s   = 1'b1;
          end else begin
            state_next_s  = ST_ADDR;
            hsel_next_s   = 1'b1;
            htrans_next_s = HTRANS_NONSEQ;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end

      ST_ADDR: begin
        if (HREADY_i) begin
          state_next_s  = ST_DATA;
          hwdata_next_s = hwdata_rep_s;
        end else if (tmo_hit_s) begin
          state_next_s     = ST_RESP;
          cnt_next_s       = cnt_inc_s;
          rsp_valid_next_s = 1'b1;
          rsp_err_next_s   = 1'b1;
          rsp_tmo_next_s   = 1'b1;
        end else begin
          cnt_next_s    = cnt_inc_s;
          hsel_next_s   = 1'b1;
          htrans_next_s = HTRANS_NONSEQ;
        end
      end

      ST_DATA: begin
        if (HREADY_i) begin
          state_next_s     = ST_RESP;
          rsp_valid_next_s = 1'b1;
          if (hresp_ok_s) begin
            rsp_rdata_next_s = write_r ? {DATA_W{1'b0}} : rdata_ext_s;
          end else begin
            rsp_err_next_s = 1'b1;
          end
        end else if (tmo_hit_s) begin
          state_next_s     = ST_RESP;
          cnt_next_s       = cnt_inc_s;
          rsp_valid_next_s = 1'b1;
          rsp_err_next_s   = 1'b1;
          rsp_tmo_next_s   = 1'b1;
        end else if (!hresp_ok_s) begin
          state_next_s = ST_ERR;
          cnt_next_s   = cnt_inc_s;
        end else begin
          cnt_next_s = cnt_inc_s;
        end
      end

      ST_ERR: begin
        if (HREADY_i) begin
          state_next_s     = ST_RESP;
          rsp_valid_next_s = 1'b1;
          rsp_err_next_s   = 1'b1;
        end else if (tmo_hit_s) begin
          state_next_s     = ST_RESP;
          cnt_next_s       = cnt_inc_s;
          rsp_valid_next_s = 1'b1;
          rsp_err_next_s   = 1'b1;
          rsp_tmo_next_s   = 1'b1;
        end else begin
          cnt_next_s = cnt_inc_s;
        end
      end

      ST_RESP: begin
        state_next_s = ST_IDLE;
      end

      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, request capture and registered outputs; reset drops any response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      addr_r      <= {ADDR_W{1'b0}};
      size_r      <= 3'b000;
      write_r     <= 1'b0;
      wdata_r     <= {DATA_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      hsel_r      <= 1'b0;
      htrans_r    <= HTRANS_IDLE;
      hwdata_r    <= {DATA_W{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DATA_W{1'b0}};
      rsp_err_r   <= 1'b0;
      rsp_tmo_r   <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      addr_r      <= addr_next_s;
      size_r      <= size_next_s;
      write_r     <= write_next_s;
      wdata_r     <= wdata_next_s;
      cnt_r       <= cnt_next_s;
      hsel_r      <= hsel_next_s;
      htrans_r    <= htrans_next_s;
      hwdata_r    <= hwdata_next_s;
      rsp_valid_r <= rsp_valid_next_s;
      rsp_rdata_r <= rsp_rdata_next_s;
      rsp_err_r   <= rsp_err_next_s;
      rsp_tmo_r   <= rsp_tmo_next_s;
    end
  end

endmodule

// File: tb/tb_ahb_lite_master_if.sv
// Directed self-checking bench for ahb_lite_master_if (TIMEOUT_CYCLES = 8).
module tb_ahb_lite_master_if;

  logic        clk;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [2:0]  req_size_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_tmo_o;
  logic        HSEL_o;
  logic [1:0]  HTRANS_o;
  logic        HWRITE_o;
  logic [2:0]  HSIZE_o;
  logic [2:0]  HBURST_o;
  logic [31:0] HADDR_o;
  logic [31:0] HWDATA_o;
  logic        HREADY_i;
  logic [1:0]  HRESP_i;
  logic [31:0] HRDATA_i;

  int checks = 0;
  int errors = 0;

  ahb_lite_master_if #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_write_i (req_write_i),
    .req_size_i  (req_size_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .rsp_tmo_o   (rsp_tmo_o),
    .HSEL_o      (HSEL_o),
    .HTRANS_o    (HTRANS_o),
    .HWRITE_o    (HWRITE_o),
    .HSIZE_o     (HSIZE_o),
    .HBURST_o    (HBURST_o),
    .HADDR_o     (HADDR_o),
    .HWDATA_o    (HWDATA_o),
    .HREADY_i    (HREADY_i),
    .HRESP_i     (HRESP_i),
    .HRDATA_i    (HRDATA_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [2:0] sz, input logic [31:0] addr,
                       input logic [31:0] wd);
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_size_i  = sz;
    req_addr_i  = addr;
    req_wdata_i = wd;
  endtask

  // Legal transfer with `waits` HREADY-low cycles in the data phase.
  task automatic run_ok(input string tag, input logic wr, input logic [2:0] sz,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input logic [31:0] exp_hw,
                        input logic [31:0] exp_rd, input int waits);
    issue(wr, sz, addr, wd);
    chk({tag, "_ready"}, {31'd0, req_ready_o}, 32'd1);
    tick();                                   // T+1 address phase
    req_valid_i = 1'b0;
    chk({tag, "_htrans_a"}, {30'd0, HTRANS_o}, 32'd2);
    chk({tag, "_hsel_a"}, {31'd0, HSEL_o}, 32'd1);
    chk({tag, "_haddr"}, HADDR_o, addr);
    chk({tag, "_hwrite"}, {31'd0, HWRITE_o}, {31'd0, wr});
    chk({tag, "_hsize"}, {29'd0, HSIZE_o}, {29'd0, sz});
    chk({tag, "_hburst"}, {29'd0, HBURST_o}, 32'd0);
    tick();                                   // T+2 data phase
    chk({tag, "_htrans_d"}, {30'd0, HTRANS_o}, 32'd0);
    chk({tag, "_hsel_d"}, {31'd0, HSEL_o}, 32'd0);
    if (wr) chk({tag, "_hwdata"}, HWDATA_o, exp_hw);
    for (int i = 0; i < waits; i++) begin
      HREADY_i = 1'b0;
      tick();
      chk({tag, "_wait_novalid"}, {31'd0, rsp_valid_o}, 32'd0);
    end
    HREADY_i = 1'b1;
    HRDATA_i = rd;
    tick();                                   // response cycle
    HRDATA_i = 32'h0000_0000;
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid_o}, 32'd1);
    chk({tag, "_rsp_err"}, {31'd0, rsp_err_o}, 32'd0);
    chk({tag, "_rsp_tmo"}, {31'd0, rsp_tmo_o}, 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata_o, exp_rd);
    tick();
    chk({tag, "_rsp_drop"}, {31'd0, rsp_valid_o}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, req_ready_o}, 32'd1);
  endtask

  // Request rejected without a bus transfer (misaligned or illegal size).
  task automatic run_bad(input string tag, input logic [2:0] sz, input logic [31:0] addr);
    issue(1'b1, sz, addr, 32'h1234_5678);
    tick();                                   // T+1
    req_valid_i = 1'b0;
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid_o}, 32'd1);
    chk({tag, "_rsp_err"}, {31'd0, rsp_err_o}, 32'd1);
    chk({tag, "_rsp_tmo"}, {31'd0, rsp_tmo_o}, 32'd0);
    chk({tag, "_htrans"}, {30'd0, HTRANS_o}, 32'd0);
    chk({tag, "_hsel"}, {31'd0, HSEL_o}, 32'd0);
    tick();
    chk({tag, "_htrans2"}, {30'd0, HTRANS_o}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, req_ready_o}, 32'd1);
  endtask

  initial begin
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_write_i = 1'b0;
    req_size_i  = 3'b000;
    req_addr_i  = 32'h0000_0000;
    req_wdata_i = 32'h0000_0000;
    HREADY_i    = 1'b1;
    HRESP_i     = 2'b00;
    HRDATA_i    = 32'h0000_0000;
    tick();
    tick();
    rst_i = 1'b0;
    chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst_htrans", {30'd0, HTRANS_o}, 32'd0);
    chk("rst_hsel", {31'd0, HSEL_o}, 32'd0);
    chk("rst_haddr", HADDR_o, 32'd0);
    chk("rst_hwdata", HWDATA_o, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);

    run_ok("word_st", 1'b1, 3'b010, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0000_0000,
           32'hDEAD_BEEF, 32'h0000_0000, 0);
    run_ok("byte_ld", 1'b0, 3'b000, 32'h1000_0003, 32'h0000_0000, 32'hAB00_0000,
           32'h0000_0000, 32'h0000_00AB, 2);
    run_ok("half_ld", 1'b0, 3'b001, 32'h1000_0006, 32'h0000_0000, 32'hCAFE_5678,
           32'h0000_0000, 32'h0000_CAFE, 0);
    run_ok("byte_st", 1'b1, 3'b000, 32'h1000_0001, 32'h0000_00A5, 32'h0000_0000,
           32'hA5A5_A5A5, 32'h0000_0000, 1);
    run_ok("half_st", 1'b1, 3'b001, 32'h1000_0002, 32'h0000_1234, 32'h0000_0000,
           32'h1234_1234, 32'h0000_0000, 0);
    run_ok("word_ld", 1'b0, 3'b010, 32'h1000_0008, 32'h0000_0000, 32'h8765_4321,
           32'h0000_0000, 32'h8765_4321, 0);

    run_bad("mis_half", 3'b001, 32'h1000_0001);
    run_bad("mis_word", 3'b010, 32'h1000_0002);
    run_bad("bad_size", 3'b011, 32'h1000_0000);

    // Two-cycle ERROR response in the data phase.
    issue(1'b0, 3'b010, 32'h1000_000C, 32'h0000_0000);
    tick();                                   // T+1 ADDR
    req_valid_i = 1'b0;
    tick();                                   // T+2 DATA
    HREADY_i = 1'b0;
    HRESP_i  = 2'b01;
    tick();                                   // T+3 ERR
    chk("err_htrans", {30'd0, HTRANS_o}, 32'd0);
    chk("err_novalid", {31'd0, rsp_valid_o}, 32'd0);
    chk("err_ready", {31'd0, req_ready_o}, 32'd0);
    HREADY_i = 1'b1;
    HRDATA_i = 32'hFFFF_FFFF;
    tick();                                   // T+4 RESP
    HRESP_i  = 2'b00;
    HRDATA_i = 32'h0000_0000;
    chk("err_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
    chk("err_rsp_err", {31'd0, rsp_err_o}, 32'd1);
    chk("err_rsp_tmo", {31'd0, rsp_tmo_o}, 32'd0);
    chk("err_rsp_rdata", rsp_rdata_o, 32'd0);
    tick();

    // Slave never ready: abort after 8 wait cycles.
    issue(1'b1, 3'b010, 32'h1000_0010, 32'h5555_AAAA);
    HREADY_i = 1'b0;
    tick();                                   // T+1
    req_valid_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("tmo_htrans_hold", {30'd0, HTRANS_o}, 32'd2);
      chk("tmo_novalid", {31'd0, rsp_valid_o}, 32'd0);
      tick();
    end
    chk("tmo_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
    chk("tmo_rsp_err", {31'd0, rsp_err_o}, 32'd1);
    chk("tmo_rsp_tmo", {31'd0, rsp_tmo_o}, 32'd1);
    chk("tmo_htrans", {30'd0, HTRANS_o}, 32'd0);
    chk("tmo_hsel", {31'd0, HSEL_o}, 32'd0);
    HREADY_i = 1'b1;
    tick();
    run_ok("post_tmo", 1'b0, 3'b010, 32'h1000_0004, 32'h0000_0000, 32'h1234_5678,
           32'h0000_0000, 32'h1234_5678, 0);

    // Reset asserted during the data phase drops the transfer.
    issue(1'b1, 3'b010, 32'h1000_0020, 32'hCAFE_F00D);
    tick();                                   // T+1 ADDR
    req_valid_i = 1'b0;
    tick();                                   // T+2 DATA
    HREADY_i = 1'b0;
    rst_i    = 1'b1;
    tick();
    chk("rstd_htrans", {30'd0, HTRANS_o}, 32'd0);
    chk("rstd_hsel", {31'd0, HSEL_o}, 32'd0);
    chk("rstd_haddr", HADDR_o, 32'd0);
    chk("rstd_hwdata", HWDATA_o, 32'd0);
    chk("rstd_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    rst_i    = 1'b0;
    HREADY_i = 1'b1;
    chk("rstd_ready", {31'd0, req_ready_o}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstd_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
